chatbot_soc_ocm_arbiter: RTL and testbench

//  Two-requester Avalon-MM arbiter for the SoC's single-port on-chip RAM (1-cycle read latency,

---
 rtl/chatbot_soc_ocm_arbiter_if.sv | 27 ++
 rtl/chatbot_soc_ocm_arbiter.sv | 109 ++++++++++
 tb/tb_chatbot_soc_ocm_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/chatbot_soc_ocm_arbiter_if.sv
// Avalon-MM master-side bus bundle for one requester of the on-chip RAM arbiter.
// The master modport drives requests and the slave modport returns waitrequest and read data.
interface chatbot_soc_ocm_arbiter_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/chatbot_soc_ocm_arbiter.sv
// Two-master arbiter for a single-port on-chip RAM with a registered issue stage and 2-cycle reads.
// Define OCM_ARB_FIXED_PRIO_EN for fixed master-0 priority; default is round-robin.
module chatbot_soc_ocm_arbiter #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    chatbot_soc_ocm_arbiter_if.slave m0,
    chatbot_soc_ocm_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [DATA_W/8-1:0]     mem_byteenable,
    output logic                    mem_chipselect,
    output logic                    mem_write,
    output logic [DATA_W-1:0]       mem_writedata,
    output logic                    mem_clken,
    input  logic [DATA_W-1:0]       mem_readdata
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              req0, req1;
    logic              grant0, grant1;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_write;

    // last_grant_q holds the index of the most recently accepted master
    logic              last_grant_q;
    logic              mem_cs_q, mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [BE_W-1:0]   mem_be_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              rd_pend_q, rd_owner_q;
    logic              rv0_q, rv1_q;

    always_comb begin
        req0   = m0.read | m0.write;
        req1   = m1.read | m1.write;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
`ifdef OCM_ARB_FIXED_PRIO_EN
                grant0 = 1'b1;
`else
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
`endif
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    always_comb begin
        accept    = grant0 | grant1;
        sel_addr  = grant1 ? m1.address : m0.address;
        sel_write = grant1 ? m1.write : m0.write;
        sel_wdata = grant1 ? m1.writedata : m0.writedata;
        // Reads always fetch the full word
        sel_be    = sel_write ? (grant1 ? m1.byteenable : m0.byteenable) : {BE_W{1'b1}};
    end

    assign m0.waitrequest = reset | (req0 & ~grant0);
    assign m1.waitrequest = reset | (req1 & ~grant1);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            mem_cs_q     <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            rv0_q        <= 1'b0;
            rv1_q        <= 1'b0;
        end else begin
            mem_cs_q    <= accept;
            mem_write_q <= accept & sel_write;
            rd_pend_q   <= accept & ~sel_write;
            rd_owner_q  <= grant1;
            rv0_q       <= rd_pend_q & ~rd_owner_q;
            rv1_q       <= rd_pend_q & rd_owner_q;
            if (accept) begin
                last_grant_q <= grant1;
                mem_addr_q   <= sel_addr;
                mem_be_q     <= sel_be;
                mem_wdata_q  <= sel_wdata;
            end
        end
    end

    assign mem_address    = mem_addr_q;
    assign mem_byteenable = mem_be_q;
    assign mem_chipselect = mem_cs_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_wdata_q;
    assign mem_clken      = 1'b1;

    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign m0.readdatavalid = rv0_q;
    assign m1.readdatavalid = rv1_q;
endmodule

// File: tb/tb_chatbot_soc_ocm_arbiter.sv
// Directed bench for the OCM arbiter with a behavioural single-port RAM behind it.
module tb_chatbot_soc_ocm_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata = '0;
    logic [31:0] ram [0:3] = '{32'h11223344, 32'h11111111, 32'h00000000, 32'h33333333};

    int checks = 0;
    int errors = 0;
    int cnt0, cnt1;

    chatbot_soc_ocm_arbiter_if #(.ADDR_W(2), .DATA_W(32)) m0_if ();
    chatbot_soc_ocm_arbiter_if #(.ADDR_W(2), .DATA_W(32)) m1_if ();

    chatbot_soc_ocm_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_if.slave),
        .m1             (m1_if.slave),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_if.read = 0; m0_if.write = 0; m0_if.address = '0; m0_if.byteenable = '0;
        m0_if.writedata = '0;
        m1_if.read = 0; m1_if.write = 0; m1_if.address = '0; m1_if.byteenable = '0;
        m1_if.writedata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        #1;
        // Reset state
        tick();
        chk("rst_wait0", {31'd0, m0_if.waitrequest}, 32'd1);
        chk("rst_wait1", {31'd0, m1_if.waitrequest}, 32'd1);
        chk("rst_cs", {31'd0, mem_chipselect}, 32'd0);
        chk("rst_addr", {30'd0, mem_address}, 32'd0);
        chk("rst_wdata", mem_writedata, 32'd0);
        chk("rst_clken", {31'd0, mem_clken}, 32'd1);
        reset = 1'b0;
        #1;

        // 1: m0 write then read back
        m0_if.write = 1; m0_if.address = 2'd2; m0_if.writedata = 32'hDEADBEEF;
        m0_if.byteenable = 4'hF;
        #1 chk("t1_wr_wait", {31'd0, m0_if.waitrequest}, 32'd0);
        tick();
        chk("t1_wr_cs", {31'd0, mem_chipselect}, 32'd1);
        chk("t1_wr_we", {31'd0, mem_write}, 32'd1);
        chk("t1_wr_addr", {30'd0, mem_address}, 32'd2);
        chk("t1_wr_data", mem_writedata, 32'hDEADBEEF);
        idle();
        m0_if.read = 1; m0_if.address = 2'd2;
        #1 chk("t1_rd_wait", {31'd0, m0_if.waitrequest}, 32'd0);
        tick();
        idle();
        chk("t1_rd_cs", {31'd0, mem_chipselect}, 32'd1);
        chk("t1_rd_we", {31'd0, mem_write}, 32'd0);
        chk("t1_rd_be", {28'd0, mem_byteenable}, 32'hF);
        chk("t1_rv_early", {31'd0, m0_if.readdatavalid}, 32'd0);
        tick();
        chk("t1_rv0", {31'd0, m0_if.readdatavalid}, 32'd1);
        chk("t1_rdata", m0_if.readdata, 32'hDEADBEEF);
        chk("t1_rv1", {31'd0, m1_if.readdatavalid}, 32'd0);
        tick();
        chk("t1_rv0_pulse", {31'd0, m0_if.readdatavalid}, 32'd0);

        // 2: simultaneous reads after reset, m0 first
        do_reset();
        m0_if.read = 1; m0_if.address = 2'd1;
        m1_if.read = 1; m1_if.address = 2'd3;
        #1;
        chk("t2_n_wait0", {31'd0, m0_if.waitrequest}, 32'd0);
        chk("t2_n_wait1", {31'd0, m1_if.waitrequest}, 32'd1);
        tick();
        m0_if.read = 0;
        #1 chk("t2_n1_wait1", {31'd0, m1_if.waitrequest}, 32'd0);
        chk("t2_n1_addr", {30'd0, mem_address}, 32'd1);
        tick();
        idle();
        chk("t2_n2_rv0", {31'd0, m0_if.readdatavalid}, 32'd1);
        chk("t2_n2_rv1", {31'd0, m1_if.readdatavalid}, 32'd0);
        chk("t2_n2_data", m0_if.readdata, 32'h11111111);
        tick();
        chk("t2_n3_rv0", {31'd0, m0_if.readdatavalid}, 32'd0);
        chk("t2_n3_rv1", {31'd0, m1_if.readdatavalid}, 32'd1);
        chk("t2_n3_data", m1_if.readdata, 32'h33333333);

        // 3: continuous contention for 8 cycles; last grant was m1 so m0 starts
        cnt0 = 0; cnt1 = 0;
        m0_if.read = 1; m0_if.address = 2'd0;
        m1_if.read = 1; m1_if.address = 2'd1;
        for (int i = 0; i < 8; i++) begin
            #1;
`ifdef OCM_ARB_FIXED_PRIO_EN
            chk("t3_wait1", {31'd0, m1_if.waitrequest}, 32'd1);
`else
            chk("t3_wait1", {31'd0, m1_if.waitrequest}, (i % 2 == 0) ? 32'd1 : 32'd0);
`endif
            tick();
            cnt0 += int'(m0_if.readdatavalid);
            cnt1 += int'(m1_if.readdatavalid);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt0 += int'(m0_if.readdatavalid);
            cnt1 += int'(m1_if.readdatavalid);
        end
`ifdef OCM_ARB_FIXED_PRIO_EN
        chk("t3_cnt0", cnt0, 32'd8);
        chk("t3_cnt1", cnt1, 32'd0);
`else
        chk("t3_cnt0", cnt0, 32'd4);
        chk("t3_cnt1", cnt1, 32'd4);
`endif

        // 4: m1 byte-lane write into addr 0
        m1_if.write = 1; m1_if.address = 2'd0; m1_if.byteenable = 4'h2;
        m1_if.writedata = 32'h0000AA00;
        tick();
        chk("t4_be", {28'd0, mem_byteenable}, 32'h2);
        idle();
        m1_if.read = 1; m1_if.address = 2'd0;
        tick();
        idle();
        tick();
        chk("t4_rv1", {31'd0, m1_if.readdatavalid}, 32'd1);
        chk("t4_data", m1_if.readdata, 32'h1122AA44);

        // 5: m0 write then immediate m1 read of the same word
        m0_if.write = 1; m0_if.address = 2'd1; m0_if.byteenable = 4'hF;
        m0_if.writedata = 32'h5;
        tick();
        idle();
        m1_if.read = 1; m1_if.address = 2'd1;
        tick();
        idle();
        tick();
        chk("t5_rv1", {31'd0, m1_if.readdatavalid}, 32'd1);
        chk("t5_rv0", {31'd0, m0_if.readdatavalid}, 32'd0);
        chk("t5_data", m1_if.readdata, 32'h00000005);

        // 6: reset right after a read is accepted drops it
        m0_if.read = 1; m0_if.address = 2'd2;
        tick();
        reset = 1'b1;
        m1_if.read = 1; m1_if.address = 2'd3;
        #1;
        chk("t6_wait0", {31'd0, m0_if.waitrequest}, 32'd1);
        chk("t6_wait1", {31'd0, m1_if.waitrequest}, 32'd1);
        tick();
        chk("t6_rv0", {31'd0, m0_if.readdatavalid}, 32'd0);
        chk("t6_cs", {31'd0, mem_chipselect}, 32'd0);
        tick();
        chk("t6_cs_hold", {31'd0, mem_chipselect}, 32'd0);
        chk("t6_rv0_late", {31'd0, m0_if.readdatavalid}, 32'd0);
        reset = 1'b0;
        #1;
        chk("t6_post_wait0", {31'd0, m0_if.waitrequest}, 32'd0);
        chk("t6_post_wait1", {31'd0, m1_if.waitrequest}, 32'd1);
        tick();
        idle();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
